// File: rtl/gpio_irq.sv
// gpio_irq: memory-mapped GPIO peripheral for the MMIO slot bus.
// Drives NUM_OUTPUT output pins. Samples NUM_INPUT asynchronous input pins
// through a 2-flop synchroniser and a filter stage. Per-pin edge detection
// sets sticky interrupt status bits, and a registered level irq is raised
// from the enabled status bits.
// Optional feature macro: GPIO_DEBOUNCE_EN. When it is defined, each input
// is debounced over DEBOUNCE_CYCLES stable cycles. When it is undefined,
// the filter stage is a single register.
module gpio_irq #(
    parameter int NUM_INPUT       = 9,
    parameter int NUM_OUTPUT      = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  chip_select,
    input  logic                  read,
    input  logic                  write,
    input  logic                  transaction_completed,
    input  logic [7:0]            addr,
    input  logic [31:0]           wr_data,
    output logic [31:0]           rd_data,
    output logic                  wr_done,
    output logic                  rd_done,
    output logic                  idle,
    output logic                  slave_error,
    output logic                  decode_error,
    input  logic [NUM_INPUT-1:0]  in_ports,
    output logic [NUM_OUTPUT-1:0] out_ports,
    output logic                  irq
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [7:0] A_OUT  = 8'h00;
    localparam logic [7:0] A_SET  = 8'h04;
    localparam logic [7:0] A_CLR  = 8'h08;
    localparam logic [7:0] A_IN   = 8'h0C;
    localparam logic [7:0] A_EN   = 8'h10;
    localparam logic [7:0] A_EDGE = 8'h14;
    localparam logic [7:0] A_STAT = 8'h18;

    state_t                  state_q, state_d;
    logic [NUM_OUTPUT-1:0]   out_q, out_d;
    logic [NUM_INPUT-1:0]    sync1_q, sync1_d;
    logic [NUM_INPUT-1:0]    sync2_q, sync2_d;
    logic [NUM_INPUT-1:0]    filt_q, filt_d;
    logic [NUM_INPUT-1:0]    irq_en_q, irq_en_d;
    logic [NUM_INPUT-1:0]    irq_edge_q, irq_edge_d;
    logic [NUM_INPUT-1:0]    status_q, status_d;
    logic [31:0]             rd_data_q, rd_data_d;
    logic                    wr_done_q, wr_done_d;
    logic                    rd_done_q, rd_done_d;
    logic                    slave_error_q, slave_error_d;
    logic                    decode_error_q, decode_error_d;
    logic                    irq_q, irq_d;

    logic                    addr_valid, addr_ro, addr_wo;
    logic                    acc_dec_err, acc_slv_err, acc_ok;
    logic [NUM_INPUT-1:0]    w1c_mask, set_ev;
    logic [31:0]             rd_val;
    logic                    unused_wr_data;

    // Upper write-data bits beyond the register widths are ignored.
    assign unused_wr_data = ^wr_data;

    // Decode the address and classify the access as legal, wrong-direction or unmapped.
    always_comb begin
        addr_valid = 1'b1;
        addr_ro    = 1'b0;
        addr_wo    = 1'b0;
        case (addr)
            A_OUT, A_EN, A_EDGE, A_STAT: begin end
            A_SET, A_CLR:                addr_wo = 1'b1;
            A_IN:                        addr_ro = 1'b1;
            default:                     addr_valid = 1'b0;
        endcase
        acc_dec_err = ~addr_valid;
        acc_slv_err = addr_valid & (write ? addr_ro : addr_wo);
        acc_ok      = addr_valid & ~acc_slv_err;
    end

    // Read mux; registers narrower than 32 bits are zero-extended.
    always_comb begin
        rd_val = '0;
        case (addr)
            A_OUT:   rd_val = 32'(out_q);
            A_IN:    rd_val = 32'(filt_q);
            A_EN:    rd_val = 32'(irq_en_q);
            A_EDGE:  rd_val = 32'(irq_edge_q);
            A_STAT:  rd_val = 32'(status_q);
            default: rd_val = '0;
        endcase
    end

    // Two-flop synchroniser for the asynchronous pins.
    always_comb begin
        sync1_d = in_ports;
        sync2_d = sync1_q;
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q [NUM_INPUT];
    logic [CNT_W-1:0] cnt_d [NUM_INPUT];

    // Accept a new pin level only after it has differed from filt for DEBOUNCE_CYCLES edges.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < NUM_INPUT; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Debounce counter registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < NUM_INPUT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    // Without debouncing the filter stage is a plain register of the synchroniser.
    always_comb begin
        filt_d = sync2_q;
    end
`endif

    // Slot FSM plus register-file updates, read data, done pulses and error flags.
    always_comb begin
        state_d        = state_q;
        out_d          = out_q;
        irq_en_d       = irq_en_q;
        irq_edge_d     = irq_edge_q;
        w1c_mask       = '0;
        rd_data_d      = rd_data_q;
        wr_done_d      = 1'b0;
        rd_done_d      = 1'b0;
        slave_error_d  = slave_error_q;
        decode_error_d = decode_error_q;
        case (state_q)
            ST_IDLE: begin
                if (chip_select && (read || write)) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                state_d        = ST_DONE;
                wr_done_d      = write;
                rd_done_d      = ~write;
                slave_error_d  = acc_slv_err;
                decode_error_d = acc_dec_err;
                if (write) begin
                    if (acc_ok) begin
                        case (addr)
                            A_OUT:   out_d      = wr_data[NUM_OUTPUT-1:0];
                            A_SET:   out_d      = out_q | wr_data[NUM_OUTPUT-1:0];
                            A_CLR:   out_d      = out_q & ~wr_data[NUM_OUTPUT-1:0];
                            A_EN:    irq_en_d   = wr_data[NUM_INPUT-1:0];
                            A_EDGE:  irq_edge_d = wr_data[NUM_INPUT-1:0];
                            A_STAT:  w1c_mask   = wr_data[NUM_INPUT-1:0];
                            default: begin end
                        endcase
                    end
                end else begin
                    rd_data_d = acc_ok ? rd_val : '0;
                end
            end
            ST_DONE: begin
                if (transaction_completed) begin
                    state_d        = ST_IDLE;
                    slave_error_d  = 1'b0;
                    decode_error_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Edge detection on filt; a new event wins over a simultaneous W1C.
    always_comb begin
        set_ev   = (filt_d ^ filt_q) & (filt_d ^ irq_edge_q);
        status_d = (status_q & ~w1c_mask) | set_ev;
        irq_d    = |(status_q & irq_en_q);
    end

    // State and register storage, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q        <= ST_IDLE;
            out_q          <= '0;
            sync1_q        <= '0;
            sync2_q        <= '0;
            filt_q         <= '0;
            irq_en_q       <= '0;
            irq_edge_q     <= '0;
            status_q       <= '0;
            rd_data_q      <= '0;
            wr_done_q      <= 1'b0;
            rd_done_q      <= 1'b0;
            slave_error_q  <= 1'b0;
            decode_error_q <= 1'b0;
            irq_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            out_q          <= out_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            filt_q         <= filt_d;
            irq_en_q       <= irq_en_d;
            irq_edge_q     <= irq_edge_d;
            status_q       <= status_d;
            rd_data_q      <= rd_data_d;
            wr_done_q      <= wr_done_d;
            rd_done_q      <= rd_done_d;
            slave_error_q  <= slave_error_d;
            decode_error_q <= decode_error_d;
            irq_q          <= irq_d;
        end
    end

    assign rd_data      = rd_data_q;
    assign wr_done      = wr_done_q;
    assign rd_done      = rd_done_q;
    assign slave_error  = slave_error_q;
    assign decode_error = decode_error_q;
    assign idle         = (state_q == ST_IDLE);
    assign out_ports    = out_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_gpio_irq.sv
// Testbench for gpio_irq: directed steps followed by randomized accesses and
// pin activity, checked against a register-level behavioural model.
module tb_gpio_irq;

    localparam int          NI    = 9;
    localparam int          NO    = 4;
    localparam int          DB    = 16;
    localparam logic [31:0] IMASK = (32'd1 << NI) - 32'd1;
    localparam logic [31:0] OMASK = (32'd1 << NO) - 32'd1;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          chip_select, read, write, transaction_completed;
    logic [7:0]    addr;
    logic [31:0]   wr_data;
    logic [31:0]   rd_data;
    logic          wr_done, rd_done, idle, slave_error, decode_error;
    logic [NI-1:0] in_ports;
    logic [NO-1:0] out_ports;
    logic          irq;

    always #5 clk = ~clk;

    gpio_irq #(
        .NUM_INPUT      (NI),
        .NUM_OUTPUT     (NO),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk                  (clk),
        .arst_n               (arst_n),
        .chip_select          (chip_select),
        .read                 (read),
        .write                (write),
        .transaction_completed(transaction_completed),
        .addr                 (addr),
        .wr_data              (wr_data),
        .rd_data              (rd_data),
        .wr_done              (wr_done),
        .rd_done              (rd_done),
        .idle                 (idle),
        .slave_error          (slave_error),
        .decode_error         (decode_error),
        .in_ports             (in_ports),
        .out_ports            (out_ports),
        .irq                  (irq)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: register contents as software sees them.
    logic [31:0] m_out, m_en, m_edge, m_status, m_filt, m_rd, m_pin1, m_pin2;
    logic        m_irq;
`ifdef GPIO_DEBOUNCE_EN
    int          m_run [NI];
`endif
    // Access committing at the coming clock edge.
    logic        m_commit, m_cwr;
    logic [7:0]  m_caddr;
    logic [31:0] m_cdata;

    // {decode_error, slave_error} expected for an access.
    function automatic logic [1:0] classify(input logic wr, input logic [7:0] a);
        case (a)
            8'h00, 8'h10, 8'h14, 8'h18: return 2'b00;
            8'h04, 8'h08:               return wr ? 2'b00 : 2'b01;
            8'h0C:                      return wr ? 2'b01 : 2'b00;
            default:                    return 2'b10;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out = 0; m_en = 0; m_edge = 0; m_status = 0; m_filt = 0; m_rd = 0;
        m_pin1 = 0; m_pin2 = 0; m_irq = 0;
`ifdef GPIO_DEBOUNCE_EN
        for (int i = 0; i < NI; i++) m_run[i] = 0;
`endif
    endtask

    // One clock edge of model behaviour.
    task automatic model_step();
        logic [31:0] nf, sets, w1c, rv;
        logic [1:0]  k;
        if (!arst_n) begin
            model_reset();
            return;
        end
        // The filter sees the pin level sampled two edges earlier.
        nf = m_filt;
`ifdef GPIO_DEBOUNCE_EN
        for (int i = 0; i < NI; i++) begin
            if (m_pin2[i] != m_filt[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    nf[i]    = m_pin2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
`else
        nf = m_pin2;
`endif
        sets  = ((nf & ~m_filt & ~m_edge) | (~nf & m_filt & m_edge)) & IMASK;
        m_irq = |(m_status & m_en);
        w1c   = 0;
        if (m_commit) begin
            k = classify(m_cwr, m_caddr);
            if (!m_cwr) begin
                case (m_caddr)
                    8'h00:   rv = m_out;
                    8'h0C:   rv = m_filt;
                    8'h10:   rv = m_en;
                    8'h14:   rv = m_edge;
                    8'h18:   rv = m_status;
                    default: rv = 0;
                endcase
                m_rd = (k == 2'b00) ? rv : 32'd0;
            end else if (k == 2'b00) begin
                case (m_caddr)
                    8'h00:   m_out  = m_cdata & OMASK;
                    8'h04:   m_out  = (m_out | m_cdata) & OMASK;
                    8'h08:   m_out  = m_out & ~m_cdata & OMASK;
                    8'h10:   m_en   = m_cdata & IMASK;
                    8'h14:   m_edge = m_cdata & IMASK;
                    8'h18:   w1c    = m_cdata & IMASK;
                    default: begin end
                endcase
            end
        end
        m_status = (m_status & ~w1c) | sets;
        m_filt   = nf & IMASK;
        m_pin2   = m_pin1;
        m_pin1   = 32'(in_ports);
    endtask

    // Advance one cycle: model at the rising edge, compare at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("out_ports", 32'(out_ports), m_out);
        chk("irq", 32'(irq), 32'(m_irq));
    endtask

    // Full slot transaction; transaction_completed arrives after 'hold' extra DONE cycles.
    task automatic bus(input logic wr, input logic [7:0] a, input logic [31:0] d, input int hold);
        logic [1:0] k;
        k = classify(wr, a);
        chip_select = 1'b1; read = ~wr; write = wr; addr = a; wr_data = d;
        tick();
        chk("idle_in_active", 32'(idle), 32'd0);
        chk("done_early", {30'd0, wr_done, rd_done}, 32'd0);
        m_commit = 1'b1; m_cwr = wr; m_caddr = a; m_cdata = d;
        tick();
        m_commit = 1'b0;
        chk("wr_done", 32'(wr_done), 32'(wr));
        chk("rd_done", 32'(rd_done), 32'(!wr));
        chk("slave_error", 32'(slave_error), 32'(k[0]));
        chk("decode_error", 32'(decode_error), 32'(k[1]));
        chk("rd_data", rd_data, m_rd);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("done_single", {30'd0, wr_done, rd_done}, 32'd0);
            chk("err_held", {30'd0, decode_error, slave_error}, 32'(k));
        end
        transaction_completed = 1'b1;
        tick();
        chk("done_after", {30'd0, wr_done, rd_done}, 32'd0);
        chk("err_cleared", {30'd0, decode_error, slave_error}, 32'd0);
        chk("idle_after", 32'(idle), 32'd1);
        chip_select = 1'b0; read = 1'b0; write = 1'b0; transaction_completed = 1'b0;
    endtask

    initial begin
        logic [7:0] ra;
        int         sel;
        arst_n = 1'b0; chip_select = 1'b0; read = 1'b0; write = 1'b0;
        transaction_completed = 1'b0; addr = '0; wr_data = '0; in_ports = '0;
        m_commit = 1'b0; m_cwr = 1'b0; m_caddr = '0; m_cdata = '0;
        model_reset();
        @(negedge clk);
        repeat (3) tick();
        // Reset state
        chk("rst_out", 32'(out_ports), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_flags", {27'd0, wr_done, rd_done, slave_error, decode_error, irq}, 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        arst_n = 1'b1;
        tick();

        // Output register, set and clear
        bus(1'b1, 8'h00, 32'h5, 0); chk("out_write", 32'(out_ports), 32'h5);
        bus(1'b1, 8'h04, 32'h2, 1); chk("out_set", 32'(out_ports), 32'h7);
        bus(1'b1, 8'h08, 32'h1, 0); chk("out_clr", 32'(out_ports), 32'h6);

        // Input read
        in_ports = 9'h1A5;
        repeat (25) tick();
        bus(1'b0, 8'h0C, 32'h0, 0); chk("in_read", rd_data, 32'h1A5);

        // Error accesses
        bus(1'b1, 8'h0C, 32'hFFFF_FFFF, 2);
        chk("ro_write_kept_in", 32'(out_ports), 32'h6);
        bus(1'b0, 8'h40, 32'h0, 1); chk("decode_rd_zero", rd_data, 32'h0);
        bus(1'b0, 8'h04, 32'h0, 0); chk("wo_rd_zero", rd_data, 32'h0);
        bus(1'b1, 8'h02, 32'h1, 0);

        // Edge interrupts
        in_ports = 9'h002;
        repeat (25) tick();
        bus(1'b1, 8'h10, 32'h3, 0);
        bus(1'b1, 8'h14, 32'h2, 0);
        bus(1'b1, 8'h18, 32'h1FF, 0);
        bus(1'b0, 8'h18, 32'h0, 0); chk("status_cleared", rd_data, 32'h0);
        in_ports = 9'h001;
        repeat (25) tick();
        bus(1'b0, 8'h18, 32'h0, 0); chk("status_both", rd_data, 32'h3);
        chk("irq_both", 32'(irq), 32'd1);
        bus(1'b1, 8'h18, 32'h1, 0);
        bus(1'b0, 8'h18, 32'h0, 0); chk("status_w1c0", rd_data, 32'h2);
        chk("irq_still", 32'(irq), 32'd1);
        bus(1'b1, 8'h18, 32'h2, 0); chk("irq_low", 32'(irq), 32'd0);
        bus(1'b1, 8'h14, 32'h0, 0);
        bus(1'b0, 8'h18, 32'h0, 0); chk("edge_write_no_set", rd_data, 32'h0);

`ifndef GPIO_DEBOUNCE_EN
        // W1C coinciding with a new rising edge on pin 0
        in_ports = 9'h000;
        repeat (10) tick();
        in_ports = 9'h001;
        tick();
        bus(1'b1, 8'h18, 32'h1, 0);
        bus(1'b0, 8'h18, 32'h0, 0); chk("set_wins", rd_data & 32'h1, 32'h1);
`else
        // Debounce: short glitch rejected, long pulse accepted after 18 cycles
        bus(1'b1, 8'h10, 32'h8, 0);
        in_ports = 9'h000;
        repeat (30) tick();
        bus(1'b1, 8'h18, 32'h1FF, 0);
        in_ports[3] = 1'b1; repeat (10) tick(); in_ports[3] = 1'b0;
        repeat (30) tick();
        bus(1'b0, 8'h0C, 32'h0, 0); chk("glitch_rejected", rd_data & 32'h8, 32'h0);
        in_ports[3] = 1'b1;
        repeat (18) tick(); chk("db_irq_before", 32'(irq), 32'd0);
        tick();             chk("db_irq_after", 32'(irq), 32'd1);
        repeat (5) tick(); in_ports[3] = 1'b0;
        repeat (25) tick();
        bus(1'b0, 8'h0C, 32'h0, 0); chk("db_in_read", rd_data & 32'h8, 32'h0);
`endif

        // Reset during ACTIVE aborts the transaction
        bus(1'b1, 8'h00, 32'hA, 0);
        chip_select = 1'b1; read = 1'b1; write = 1'b0; addr = 8'h00;
        tick();
        #2;
        arst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_out", 32'(out_ports), 32'd0);
        chk("mid_rst_rd_data", rd_data, 32'd0);
        chk("mid_rst_flags", {27'd0, wr_done, rd_done, slave_error, decode_error, irq}, 32'd0);
        chk("mid_rst_idle", 32'(idle), 32'd1);
        chip_select = 1'b0; read = 1'b0;
        tick();
        arst_n = 1'b1;
        tick();
        chk("no_done_after_rst", {30'd0, wr_done, rd_done}, 32'd0);
        tick();
        chk("no_done_after_rst2", {30'd0, wr_done, rd_done}, 32'd0);

        // Randomized accesses with random pin activity
        for (int it = 0; it < 120; it++) begin
            if ($urandom_range(0, 2) == 0) in_ports = NI'($urandom);
            sel = int'($urandom_range(0, 8));
            ra  = (sel < 7) ? 8'(sel * 4) : 8'($urandom);
            bus(1'($urandom_range(0, 1)), ra, $urandom, int'($urandom_range(0, 2)));
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
